// File: rtl/pin_change_irq_pkg.sv
// Shared I/O address map for the port blocks and their pin-change interrupt groups,
// plus the read-select encoding used by the pin-change register file.
package pin_change_irq_pkg;

    // I/O-space port registers (PINx, DDRx, PORTx)
    localparam logic [5:0] PINB_ADDR  = 6'h03;
    localparam logic [5:0] DDRB_ADDR  = 6'h04;
    localparam logic [5:0] PORTB_ADDR = 6'h05;
    localparam logic [5:0] PINC_ADDR  = 6'h06;
    localparam logic [5:0] DDRC_ADDR  = 6'h07;
    localparam logic [5:0] PORTC_ADDR = 6'h08;
    localparam logic [5:0] PIND_ADDR  = 6'h09;
    localparam logic [5:0] DDRD_ADDR  = 6'h0A;
    localparam logic [5:0] PORTD_ADDR = 6'h0B;
    localparam logic [5:0] PINE_ADDR  = 6'h0C;
    localparam logic [5:0] DDRE_ADDR  = 6'h0D;
    localparam logic [5:0] PORTE_ADDR = 6'h0E;

    // Pin-change interrupt registers
    localparam logic [5:0] PCIFR_ADDR  = 6'h1B;
    localparam logic [7:0] PCICR_ADDR  = 8'h68;
    localparam logic [7:0] PCMSK0_ADDR = 8'h6B;
    localparam logic [7:0] PCMSK1_ADDR = 8'h6C;
    localparam logic [7:0] PCMSK2_ADDR = 8'h6D;
    localparam logic [7:0] PCMSK3_ADDR = 8'h73;

    // Group bit positions in PCICR/PCIFR for ports B..E
    localparam int unsigned PCINT_GRP_B = 32'd0;
    localparam int unsigned PCINT_GRP_C = 32'd1;
    localparam int unsigned PCINT_GRP_D = 32'd2;
    localparam int unsigned PCINT_GRP_E = 32'd3;

    typedef enum logic [1:0] {
        RD_NONE  = 2'd0,
        RD_PCIFR = 2'd1,
        RD_PCICR = 2'd2,
        RD_PCMSK = 2'd3
    } rd_sel_e;

    // Place a single-bit register value at its group position in a byte.
    function automatic logic [7:0] grp_byte(input logic bit_v, input logic [2:0] pos);
        logic [7:0] r;
        r      = 8'h00;
        r[pos] = bit_v;
        return r;
    endfunction

endpackage

// File: rtl/pin_change_irq_if.sv
// Core-side register bus seen by a pin-change group: I/O-space and data-space
// read/write strobes, shared write data and the combinational read return.
interface pin_change_irq_if;
    logic [5:0] IO_Addr;
    logic       iore;
    logic       iowe;
    logic [7:0] ramadr;
    logic       ramre;
    logic       ramwe;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       out_en;

    modport master (
        output IO_Addr, iore, iowe, ramadr, ramre, ramwe, dbus_in,
        input  dbus_out, out_en
    );

    modport slave (
        input  IO_Addr, iore, iowe, ramadr, ramre, ramwe, dbus_in,
        output dbus_out, out_en
    );
endinterface

// File: rtl/pin_change_irq_pin_sync.sv
// Two-flop synchronizer for asynchronous pad inputs; shared by all port blocks.
module pin_sync #(
    parameter int unsigned WIDTH = 32'd8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    // metastability filter: s1 may go metastable, s2 is the clean sample
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q <= {WIDTH{1'b0}};
            s2_q <= {WIDTH{1'b0}};
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/pin_change_irq.sv
// One pin-change interrupt group: synchronizes eight pads, flags masked edges in
// PCIF, and exposes PCIFR/PCICR/PCMSK on the core register bus.
module pin_change_irq
    import pin_change_irq_pkg::*;
#(
    parameter logic [5:0]  PCIFR_Address = PCIFR_ADDR,
    parameter logic [7:0]  PCICR_Address = PCICR_ADDR,
    parameter logic [7:0]  PCMSK_Address = PCMSK0_ADDR,
    parameter int unsigned GRP_BIT       = PCINT_GRP_B
) (
    input  logic                    cp2,
    input  logic                    ireset,
    pin_change_irq_if.slave         bus,
    input  logic [7:0]              pin_i,
    output logic [7:0]              PCINT_o,
    output logic                    PCIE_o,
    output logic                    irq,
    input  logic                    irq_ack
);

    localparam logic [2:0] GRP_IDX = 3'(GRP_BIT);

    logic [7:0] pin_s2_s;
    logic [7:0] prev_q;
    logic [7:0] change_s;
    logic [7:0] pcmsk_q, pcmsk_d;
    logic       pcie_q, pcie_d;
    logic       pcif_q, pcif_d;
    logic       pcifr_wr_s, pcicr_wr_s, pcmsk_wr_s;
    logic       flag_clr_s;
    rd_sel_e    rd_sel_s;

    pin_sync #(.WIDTH(32'd8)) u_pin_sync (
        .clk_i   (cp2),
        .rst_n_i (ireset),
        .d_i     (pin_i),
        .q_o     (pin_s2_s)
    );

    assign change_s   = (pin_s2_s ^ prev_q) & pcmsk_q;
    assign pcifr_wr_s = bus.iowe  && (bus.IO_Addr == PCIFR_Address);
    assign pcicr_wr_s = bus.ramwe && (bus.ramadr  == PCICR_Address);
    assign pcmsk_wr_s = bus.ramwe && (bus.ramadr  == PCMSK_Address);
    assign flag_clr_s = (pcifr_wr_s && bus.dbus_in[GRP_IDX]) || irq_ack;

    // register next-state; a detected change outranks any clear on the same edge
    always_comb begin
        pcmsk_d = pcmsk_q;
        pcie_d  = pcie_q;
        pcif_d  = pcif_q;
        if (pcmsk_wr_s) begin
            pcmsk_d = bus.dbus_in;
        end else begin
            pcmsk_d = pcmsk_q;
        end
        if (pcicr_wr_s) begin
            pcie_d = bus.dbus_in[GRP_IDX];
        end else begin
            pcie_d = pcie_q;
        end
        if (|change_s) begin
            pcif_d = 1'b1;
        end else if (flag_clr_s) begin
            pcif_d = 1'b0;
        end else begin
            pcif_d = pcif_q;
        end
    end

    // state registers, including the edge-history sample of the synchronized pins
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            prev_q  <= 8'h00;
            pcmsk_q <= 8'h00;
            pcie_q  <= 1'b0;
            pcif_q  <= 1'b0;
        end else begin
            prev_q  <= pin_s2_s;
            pcmsk_q <= pcmsk_d;
            pcie_q  <= pcie_d;
            pcif_q  <= pcif_d;
        end
    end

    // read decode; the I/O-space read wins if the core ever overlaps both
    always_comb begin
        rd_sel_s = RD_NONE;
        if (!ireset) begin
            rd_sel_s = RD_NONE;
        end else if (bus.iore && (bus.IO_Addr == PCIFR_Address)) begin
            rd_sel_s = RD_PCIFR;
        end else if (bus.ramre && (bus.ramadr == PCICR_Address)) begin
            rd_sel_s = RD_PCICR;
        end else if (bus.ramre && (bus.ramadr == PCMSK_Address)) begin
            rd_sel_s = RD_PCMSK;
        end else begin
            rd_sel_s = RD_NONE;
        end
    end

    // read data mux
    always_comb begin
        bus.dbus_out = 8'h00;
        case (rd_sel_s)
            RD_PCIFR: bus.dbus_out = grp_byte(pcif_q, GRP_IDX);
            RD_PCICR: bus.dbus_out = grp_byte(pcie_q, GRP_IDX);
            RD_PCMSK: bus.dbus_out = pcmsk_q;
            default:  bus.dbus_out = 8'h00;
        endcase
    end

    assign bus.out_en = (rd_sel_s != RD_NONE);
    assign PCINT_o    = pcmsk_q;
    assign PCIE_o     = pcie_q;
    assign irq        = pcif_q & pcie_q;

endmodule

// File: doc/pin_change_irq.md
PIN_CHANGE_IRQ -- requirements
Module: pin_change_irq

Interface
REQ-001 SHALL have parameter PCIFR_Address, default 6'h1B, I/O-space address of the flag register.
REQ-002 SHALL have parameter PCICR_Address, default 8'h68, data-space address of the control register.
REQ-003 SHALL have parameter PCMSK_Address, default 8'h6B, data-space address of the mask register.
REQ-004 SHALL have parameter GRP_BIT, default 0, bit position of this group's PCIE/PCIF bit.
REQ-005 SHALL have cp2, input, 1, the one system clock; all flops on its rising edge.
REQ-006 SHALL have ireset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have IO_Addr, iore, iowe, inputs, 6/1/1, I/O-space bus.
REQ-008 SHALL have ramadr, ramre, ramwe, inputs, 8/1/1, data-space bus.
REQ-009 SHALL have dbus_in, input, 8, write data; dbus_out, output, 8, read data.
REQ-010 SHALL have out_en, output, 1, high while dbus_out carries a valid read.
REQ-011 SHALL have pin_i, input, 8, pad digital inputs (the port's DIB_o).
REQ-012 SHALL have PCINT_o, output, 8, mask register value (to the port's PCINT).
REQ-013 SHALL have PCIE_o, output, 1, group enable (to the port's PCIE0).
REQ-014 SHALL have irq, output, 1, interrupt request; irq_ack, input, 1, vector-taken strobe.

Function
REQ-015 Each pin_i bit SHALL pass a two-flop synchronizer (s1, s2), then a history flop prev.
REQ-016 change[n] SHALL be (s2[n] != prev[n]) AND PCMSK[n].
REQ-017 PCIF SHALL set on the cp2 edge following any change bit high: pin toggles before edge k -> PCIF high after edge k+2.
REQ-018 PCIF SHALL set on a masked change whether or not PCIE is set.
REQ-019 irq SHALL equal PCIF AND PCIE, combinational from registers.
REQ-020 Writing 1 to PCIFR bit GRP_BIT SHALL clear PCIF; writing 0 SHALL have no effect.
REQ-021 irq_ack high SHALL clear PCIF on that edge.
REQ-022 Set and clear on the same edge SHALL leave PCIF set (set wins).
REQ-023 A glitch shorter than one cp2 period may be missed; any change lasting ≥2 cycles SHALL set PCIF.
REQ-024 Multiple pin changes before clear SHALL produce a single flag; no counting.
REQ-025 A PCMSK write SHALL take effect for change detection on the following cycle; a pending s2/prev mismatch on a newly enabled bit SHALL set PCIF.
REQ-026 PCICR write (ramwe, ramadr==PCICR_Address) SHALL load PCIE from dbus_in[GRP_BIT]; other bits ignored.
REQ-027 PCMSK write SHALL load all 8 bits.
REQ-028 Reads SHALL be combinational: out_en = (iore & IO_Addr==PCIFR_Address) | (ramre & ramadr==PCICR_Address or PCMSK_Address).
REQ-029 Read data SHALL be the register value with unimplemented bits 0; dbus_out SHALL be 8'h00 when out_en low.
REQ-030 Simultaneous iore and ramre hits SHALL not occur (core guarantee); the I/O read takes priority if they do.

Reset
REQ-031 ireset low SHALL asynchronously clear s1, s2, prev, PCMSK, PCIE, PCIF.
REQ-032 Outputs during reset: irq=0, PCINT_o=8'h00, PCIE_o=0, out_en=0, dbus_out=8'h00.
REQ-033 Reset asserted mid-operation SHALL drop a pending flag; no change is detected from the reset-induced s2 transition while PCMSK is 0.
REQ-034 Reset release SHALL be synchronized externally; no internal deassertion synchronizer.

Structure
REQ-035 The default addresses and GRP_BIT SHALL live in the shared IO address package, alongside the port addresses.
REQ-036 The synchronizer SHALL be a sub-module pin_sync (parameterized width, async active-low reset), reusable by other ports.
REQ-037 One instance per pin-change group; ports B, C, D, E instantiate with GRP_BIT 0..3.

Verification
REQ-038 Reset; PCMSK=8'h01, PCIE=1; drive pin_i[0] 0->1 before edge k -> PCIF=1 and irq=1 after edge k+2, not before.
REQ-039 PCMSK=8'h01; toggle pin_i[3] -> PCIF stays 0, irq stays 0.
REQ-040 PCIF=1; write PCIFR=8'h01 -> PCIF=0; write 8'h00 when set -> PCIF stays 1.
REQ-041 Change detect and irq_ack on the same edge -> PCIF remains 1, irq remains 1.
REQ-042 PCIE=0, masked toggle -> PCIF=1, irq=0; then PCIE=1 -> irq=1 next cycle.
REQ-043 Write PCMSK=8'hA5, read PCMSK -> 8'hA5 with out_en=1; read PCICR -> 8'h01 with PCIE set; assert ireset mid-test -> all reads 8'h00 and irq=0.
